// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between a controller (master) and the sequential ALU (slave).
interface alu_seq_unit_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           func;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out;
    logic                 overflow;

    modport master (
        output start, a, b, func,
        input  busy, done, out, overflow
    );

    modport slave (
        input  start, a, b, func,
        output busy, done, out, overflow
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle signed ALU: add/sub finish in one cycle, mul/div iterate one bit per cycle.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; operands and func latched on accept
// S_CALC | one shift-add (mul) or restoring (div) step per cycle
// S_FIN  | result registers valid, done pulsed, back to S_IDLE
module alu_seq_unit #(
    parameter int WIDTH = 6
) (
    input  logic          clock,
    input  logic          reset,
    alu_seq_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [1:0]           func_r;
    logic [WIDTH-1:0]     a_r;
    logic                 neg_res;
    logic                 sign_a;
    logic                 b_zero;
    logic                 div_ovf_case;
    // mul: multiplicand shifting left; div: divisor in the low half
    logic [2*WIDTH-1:0]   mcand;
    // mul: running product; div: partial remainder in the low half
    logic [2*WIDTH-1:0]   acc;
    // mul: multiplier shifting right; div: dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]     shreg;
    logic [2*WIDTH-1:0]   out_r;
    logic                 ovf_r;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     sum_ab;
    logic [WIDTH-1:0]     diff_ab;
    logic                 ovf_add;
    logic                 ovf_sub;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   mcand_nxt;
    logic [WIDTH-1:0]     sh_nxt;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       trial_diff;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem_v;
    logic [2*WIDTH-1:0]   res_calc;
    logic                 ovf_calc;

    assign accept    = (state == S_IDLE) && bus.start;
    assign last_iter = (state == S_CALC) && (cnt == CW'(WIDTH - 1));

    // Magnitudes stay W-bit unsigned so the most negative operand maps to 2^(W-1) exactly.
    assign mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign sum_ab  = bus.a + bus.b;
    assign diff_ab = bus.a - bus.b;
    assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ab[WIDTH-1] != bus.a[WIDTH-1]);
    assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ab[WIDTH-1] != bus.a[WIDTH-1]);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = bus.func[1] ? S_CALC : S_FIN;
            S_CALC:  if (last_iter) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; done coincides with the last busy cycle.
    always_comb begin
        bus.busy = (state != S_IDLE);
        bus.done = (state == S_FIN);
    end

    // One iteration step: shift-add for mul, restoring subtract for div.
    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        sh_nxt     = shreg;
        trial      = '0;
        trial_diff = '0;
        if (func_r == 2'b10) begin
            if (shreg[0]) acc_nxt = acc + mcand;
            mcand_nxt = mcand << 1;
            sh_nxt    = shreg >> 1;
        end else begin
            trial      = {acc[WIDTH-1:0], shreg[WIDTH-1]};
            trial_diff = trial - {1'b0, mcand[WIDTH-1:0]};
            if (trial >= {1'b0, mcand[WIDTH-1:0]}) begin
                acc_nxt = {{(WIDTH-1){1'b0}}, trial_diff};
                sh_nxt  = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {{(WIDTH-1){1'b0}}, trial};
                sh_nxt  = {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and divide special cases applied to the final iteration's values.
    // The -2^(W-1) / -1 case already produces the wrapped quotient; only the flag is added.
    always_comb begin
        quo      = neg_res ? -sh_nxt : sh_nxt;
        rem_v    = sign_a ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        res_calc = '0;
        ovf_calc = 1'b0;
        if (func_r == 2'b10) begin
            res_calc = neg_res ? -acc_nxt : acc_nxt;
        end else if (b_zero) begin
            res_calc = {{WIDTH{1'b1}}, a_r};
            ovf_calc = 1'b1;
        end else begin
            res_calc = {quo, rem_v};
            ovf_calc = div_ovf_case;
        end
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            func_r       <= '0;
            a_r          <= '0;
            neg_res      <= 1'b0;
            sign_a       <= 1'b0;
            b_zero       <= 1'b0;
            div_ovf_case <= 1'b0;
            mcand        <= '0;
            acc          <= '0;
            shreg        <= '0;
            out_r        <= '0;
            ovf_r        <= 1'b0;
        end else if (accept) begin
            cnt          <= '0;
            func_r       <= bus.func;
            a_r          <= bus.a;
            neg_res      <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_a       <= bus.a[WIDTH-1];
            b_zero       <= (bus.b == '0);
            div_ovf_case <= (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
            acc          <= '0;
            mcand        <= {{WIDTH{1'b0}}, (bus.func[0] ? mag_b : mag_a)};
            shreg        <= bus.func[0] ? mag_a : mag_b;
            // add/sub results land now so they are valid in the following done cycle
            if (!bus.func[1]) begin
                out_r <= bus.func[0] ? {{WIDTH{diff_ab[WIDTH-1]}}, diff_ab}
                                     : {{WIDTH{sum_ab[WIDTH-1]}}, sum_ab};
                ovf_r <= bus.func[0] ? ovf_sub : ovf_add;
            end
        end else if (state == S_CALC) begin
            cnt   <= cnt + 1'b1;
            acc   <= acc_nxt;
            mcand <= mcand_nxt;
            shreg <= sh_nxt;
            if (last_iter) begin
                out_r <= res_calc;
                ovf_r <= ovf_calc;
            end
        end
    end

    assign bus.out      = out_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed corner cases, handshake and reset checks,
// then randomized operations compared against an integer-arithmetic reference.
module tb_alu_seq_unit;
    localparam int W = 6;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    alu_seq_unit_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic with the defined divide special cases.
    function automatic void ref_alu(input int ai, input int bi, input logic [1:0] f,
                                    output logic [2*W-1:0] ro, output logic rv);
        int r;
        int q;
        int m;
        int lo_max;
        int lo_min;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        lo_max = 2**(W-1) - 1;
        lo_min = -(2**(W-1));
        ro = '0;
        rv = 1'b0;
        case (f)
            2'b00, 2'b01: begin
                r  = (f == 2'b00) ? ai + bi : ai - bi;
                rv = (r > lo_max) || (r < lo_min);
                lo = r[W-1:0];
                ro = {{W{lo[W-1]}}, lo};
            end
            2'b10: begin
                r  = ai * bi;
                ro = r[2*W-1:0];
            end
            default: begin
                if (bi == 0) begin
                    hi = '1;
                    lo = ai[W-1:0];
                    rv = 1'b1;
                end else if (ai == lo_min && bi == -1) begin
                    hi = lo_min[W-1:0];
                    lo = '0;
                    rv = 1'b1;
                end else begin
                    q  = ai / bi;
                    m  = ai % bi;
                    hi = q[W-1:0];
                    lo = m[W-1:0];
                end
                ro = {hi, lo};
            end
        endcase
    endfunction

    // Issue one request right after an edge, scramble inputs after accept, wait for done,
    // check latency/result/busy, then step into the cycle after done.
    task automatic do_op(input int ai, input int bi, input logic [1:0] f, input string tag);
        logic [2*W-1:0] eo;
        logic           ev;
        int             n;
        logic           busy_ok;
        ref_alu(ai, bi, f, eo, ev);
        bus.start = 1'b1;
        bus.a     = ai[W-1:0];
        bus.b     = bi[W-1:0];
        bus.func  = f;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.func  = 2'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (!bus.done && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        chk({tag, " latency"}, n, (f[1] ? W + 1 : 1));
        chk({tag, " out"}, bus.out, eo);
        chk({tag, " overflow"}, bus.overflow, ev);
        chk({tag, " busy"}, busy_ok & bus.busy, 1);
        @(posedge clock); #1;
    endtask

    int n_done;
    int first_done;
    int corner[6] = '{-32, -31, -1, 0, 1, 31};

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.func  = 2'b00;
        #12;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset out", bus.out, 0);
        chk("reset overflow", bus.overflow, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        do_op(31, 1, 2'b00, "add 31+1");
        do_op(-32, 1, 2'b01, "sub -32-1");
        do_op(-1, -32, 2'b01, "sub -1-(-32)");
        do_op(-32, -32, 2'b10, "mul -32*-32");
        do_op(-5, 7, 2'b10, "mul -5*7");
        do_op(-7, 2, 2'b11, "div -7/2");
        do_op(5, 0, 2'b11, "div 5/0");
        do_op(-32, -1, 2'b11, "div -32/-1");
        do_op(31, 4, 2'b11, "div 31/4");

        // start held high for the whole mul: one done only
        bus.start = 1'b1;
        bus.a     = 6'(-5);
        bus.b     = 6'd7;
        bus.func  = 2'b10;
        @(posedge clock); #1;
        n_done = 0;
        first_done = 0;
        for (int i = 1; i <= 14; i++) begin
            if (bus.done) begin
                n_done++;
                if (first_done == 0) first_done = i;
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
        end
        chk("held start done count", n_done, 1);
        chk("held start latency", first_done, W + 1);
        chk("held start out", bus.out, 12'hFDD);

        // reset three cycles into a divide
        bus.start = 1'b1;
        bus.a     = 6'd31;
        bus.b     = 6'd4;
        bus.func  = 2'b11;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        chk("midop reset busy", bus.busy, 0);
        chk("midop reset done", bus.done, 0);
        chk("midop reset out", bus.out, 0);
        chk("midop reset overflow", bus.overflow, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done || bus.busy) n_done++;
            @(posedge clock); #1;
        end
        chk("after reset no done", n_done, 0);

        // divide by zero for every dividend
        for (int ai = -32; ai < 32; ai++) do_op(ai, 0, 2'b11, "div by zero");

        // corner operand pairs under all functions
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                for (int f = 0; f < 4; f++)
                    do_op(corner[i], corner[j], 2'(f), "corner");

        // random operations
        for (int k = 0; k < 1500; k++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 63)) - 32;
            rb = int'($urandom_range(0, 63)) - 32;
            do_op(ra, rb, 2'($urandom), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
